gate_motor_driver: RTL and testbench
====================================

// Module: gate_motor_driver
// PURPOSE
//  Drives the gate motor: turns button presses and limit-switch inputs into the
//  motor-enable / direction pair (motor, sentido) that the gate status monitor consumes.
//  Sits between the board switches/keys and the motor stage, and enforces:
//  - direction-reversal dead time
//  - travel timeout with fault latch
//  - auto-close after the gate has been open for a set time
// PARAMETERS
//  TRAVEL_MAX   5000000  max cycles motor may run in one direction before FAULT
//  DEAD_CYCLES  500000   motor-off cycles enforced before any direction change
//  AUTO_CLOSE   250000000 cycles in OPEN before closing starts automatically; 0 = disabled
// PORTS
//  clock        in   1  system clock; single clock domain
//  reset        in   1  asynchronous, active-high reset
//  botao        in   1  raw push button, 1 = pressed; asynchronous to clock
//  aberto       in   1  open limit switch, 1 = fully open; asynchronous
//  fechado      in   1  closed limit switch, 1 = fully closed; asynchronous
//  motor        out  1  1 = motor energised
//  sentido      out  1  0 = opening, 1 = closing; meaningful only while motor=1
//  ledVerde     out  1  1 while OPENING
//  ledVermelho  out  1  1 while CLOSING or FAULT
//  display      out  7  active-low 7-seg {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Inputs:
//  - botao, aberto, fechado each pass through a 2-FF synchroniser.
//  - press = rising edge of the synchronised botao; 1-cycle pulse.
//  Reset:
//  - state=STOPPED; motor=0, sentido=0, both LEDs=0.
//  - Counters cleared; display=7'b0111111.
//  Registered outputs:
//  - motor, sentido, LEDs and display are decoded from the state register.
//  - They change on the same edge as the state.
//  States and transitions (evaluated each clock, first match wins):
//  - STOPPED:
//    - fechado -> CLOSED; aberto -> OPEN.
//    - press with neither limit active -> DEAD, with next direction = closing.
//  - CLOSED: press -> DEAD (next=opening).
//  - OPEN: press, or open timer reaching AUTO_CLOSE-1 (when AUTO_CLOSE!=0) -> DEAD (next=closing).
//  - DEAD:
//    - motor=0; counts DEAD_CYCLES.
//    - At terminal count -> OPENING or CLOSING per the stored next direction.
//    - A press while in DEAD inverts the stored next direction; the count does not restart.
//  - OPENING:
//    - motor=1, sentido=0.
//    - aberto -> OPEN.
//    - press -> DEAD (next=closing), i.e. reversal.
//    - run counter reaching TRAVEL_MAX-1 -> FAULT.
//  - CLOSING:
//    - motor=1, sentido=1.
//    - fechado -> CLOSED.
//    - press -> DEAD (next=opening).
//    - run counter reaching TRAVEL_MAX-1 -> FAULT.
//  - FAULT:
//    - motor=0, ledVermelho=1.
//    - Exited only by reset.
//    - Also entered from any state when aberto and fechado are both 1 for one synchronised cycle.
//  Priority on simultaneous events:
//  - Both-limits fault has highest priority.
//  - Then the limit switch matching the current direction (beats press and timeout).
//  - Then press, then timeout.
//  Counters:
//  - One shared counter, width $clog2(max of the three parameters)+1.
//  - Cleared on every state change; saturates rather than wrapping.
//  - A limit switch seen at the same cycle as TRAVEL_MAX-1 counts as success.
//  Sentido rules:
//  - sentido never changes while motor=1.
//  - Every direction change passes through DEAD.
//  Display codes:
//  - CLOSED 7'b1000110 ('C'); OPEN 7'b0001000 ('A'); FAULT 7'b0000110 ('E').
//  - All other states 7'b0111111 ('-').
//  Reset mid-travel: motor drops to 0 asynchronously; re-home via STOPPED rules.
// STRUCTURE
//  Package gate_pkg:
//  - state encoding (3-bit enum: STOPPED, CLOSED, OPEN, DEAD, OPENING, CLOSING, FAULT)
//  - direction constants OPEN_DIR=0, CLOSE_DIR=1
//  - the four 7-seg code constants
//  Sub-module sync_edge:
//  - 2-FF synchroniser plus rising-edge pulse; instantiated for botao.
//  - Plain synchronisers (no edge output) for aberto and fechado.
//  Top: FSM, shared counter, output decode.
// TESTING (bench params TRAVEL_MAX=20, DEAD_CYCLES=3, AUTO_CLOSE=30)
//  1. Reset with fechado=1 -> CLOSED after 3 clk, display=7'b1000110, motor=0.
//  2. CLOSED, press -> motor=0 for 3 clk, then motor=1 sentido=0 ledVerde=1; aberto=1 -> OPEN within 3 clk.
//  3. OPEN, no press -> after 30 clk enter DEAD, 3 clk later motor=1 sentido=1; fechado=1 -> CLOSED.
//  4. OPENING, press at cycle 5 -> motor=0 for exactly 3 clk, then sentido=1; sentido never toggles while motor=1.
//  5. CLOSING with no limit for 20 clk -> FAULT, motor=0, display=7'b0000110; presses ignored until reset.
//  6. aberto=fechado=1 in any state -> FAULT; reset asserted mid-OPENING -> motor=0 same cycle, state STOPPED.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the gate motor driver: state encoding, direction
// values and the 7-segment glyphs shown on the status display.
package gate_pkg;

  typedef enum logic [2:0] {
    STOPPED = 3'd0,
    CLOSED  = 3'd1,
    OPEN    = 3'd2,
    DEAD    = 3'd3,
    OPENING = 3'd4,
    CLOSING = 3'd5,
    FAULT   = 3'd6
  } state_e;

  localparam logic OPEN_DIR  = 1'b0;
  localparam logic CLOSE_DIR = 1'b1;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_CLOSED = 7'b1000110;
  localparam logic [6:0] SEG_OPEN   = 7'b0001000;
  localparam logic [6:0] SEG_FAULT  = 7'b0000110;
  localparam logic [6:0] SEG_DASH   = 7'b0111111;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/gate_motor_driver_sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector producing a single-cycle pulse in the clock domain.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/gate_motor_driver.sv
// Gate motor controller: button and limit switches in, motor enable and
// direction out, with reversal dead time, travel timeout and auto-close.
module gate_motor_driver
  import gate_pkg::*;
#(
  parameter int TRAVEL_MAX  = 5000000,
  parameter int DEAD_CYCLES = 500000,
  parameter int AUTO_CLOSE  = 250000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao,
  input  logic       aberto,
  input  logic       fechado,
  output logic       motor,
  output logic       sentido,
  output logic       ledVerde,
  output logic       ledVermelho,
  output logic [6:0] display,
  output state_e     dbg_state
);

  localparam int CW = $clog2(max3(TRAVEL_MAX, DEAD_CYCLES, AUTO_CLOSE)) + 1;
  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_MAX - 1);
  localparam logic [CW-1:0] DEAD_LAST   = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] AUTO_LAST   = CW'((AUTO_CLOSE == 0) ? 0 : AUTO_CLOSE - 1);
  localparam logic [CW-1:0] CNT_SAT     = '1;

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    lim_meta_q, lim_sync_q;
  logic          press;
  logic          lim_open, lim_closed;
  logic          auto_due;

  sync_edge u_botao_sync (
    .clk    (clock),
    .rst    (reset),
    .d_i    (botao),
    .rise_o (press)
  );

  // Limit switches only need level synchronisation; bit 1 = open, bit 0 = closed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lim_meta_q <= 2'b00;
      lim_sync_q <= 2'b00;
    end else begin
      lim_meta_q <= {aberto, fechado};
      lim_sync_q <= lim_meta_q;
    end
  end

  assign lim_open   = lim_sync_q[1];
  assign lim_closed = lim_sync_q[0];
  assign auto_due   = (AUTO_CLOSE != 0) && (cnt_q == AUTO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= STOPPED;
      dir_q   <= CLOSE_DIR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Branch order inside each state encodes event priority: limit, press, timeout
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (lim_open && lim_closed) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        STOPPED: begin
          if (lim_closed)    state_d = CLOSED;
          else if (lim_open) state_d = OPEN;
          else if (press) begin
            state_d = DEAD;
            dir_d   = CLOSE_DIR;
          end
        end
        CLOSED: begin
          if (press) begin
            state_d = DEAD;
            dir_d   = OPEN_DIR;
          end
        end
        OPEN: begin
          if (press || auto_due) begin
            state_d = DEAD;
            dir_d   = CLOSE_DIR;
          end
        end
        DEAD: begin
          if (cnt_q == DEAD_LAST) state_d = (dir_q == CLOSE_DIR) ? CLOSING : OPENING;
          else if (press)         dir_d   = ~dir_q;
        end
        OPENING: begin
          if (lim_open) state_d = OPEN;
          else if (press) begin
            state_d = DEAD;
            dir_d   = CLOSE_DIR;
          end else if (cnt_q == TRAVEL_LAST) state_d = FAULT;
        end
        CLOSING: begin
          if (lim_closed) state_d = CLOSED;
          else if (press) begin
            state_d = DEAD;
            dir_d   = OPEN_DIR;
          end else if (cnt_q == TRAVEL_LAST) state_d = FAULT;
        end
        FAULT:   state_d = FAULT;
        default: state_d = STOPPED;
      endcase
    end
  end

  // One counter serves dead time, travel time and open time; restarts on any state change
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    motor       = 1'b0;
    sentido     = OPEN_DIR;
    ledVerde    = 1'b0;
    ledVermelho = 1'b0;
    display     = SEG_DASH;
    case (state_q)
      CLOSED: display = SEG_CLOSED;
      OPEN:   display = SEG_OPEN;
      OPENING: begin
        motor    = 1'b1;
        sentido  = OPEN_DIR;
        ledVerde = 1'b1;
      end
      CLOSING: begin
        motor       = 1'b1;
        sentido     = CLOSE_DIR;
        ledVermelho = 1'b1;
      end
      FAULT: begin
        ledVermelho = 1'b1;
        display     = SEG_FAULT;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_motor_driver.sv
// Bench for gate_motor_driver: directed scenarios checked every cycle against
// a behavioural model, plus literal checkpoints at key moments.
module tb_gate_motor_driver;
  import gate_pkg::*;

  localparam int TRAVEL_MAX  = 20;
  localparam int DEAD_CYCLES = 3;
  localparam int AUTO_CLOSE  = 30;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       botao = 1'b0;
  logic       aberto = 1'b0;
  logic       fechado = 1'b0;
  logic       motor, sentido, ledVerde, ledVermelho;
  logic [6:0] display;
  state_e     dbg_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  gate_motor_driver #(
    .TRAVEL_MAX  (TRAVEL_MAX),
    .DEAD_CYCLES (DEAD_CYCLES),
    .AUTO_CLOSE  (AUTO_CLOSE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .botao       (botao),
    .aberto      (aberto),
    .fechado     (fechado),
    .motor       (motor),
    .sentido     (sentido),
    .ledVerde    (ledVerde),
    .ledVermelho (ledVermelho),
    .display     (display),
    .dbg_state   (dbg_state)
  );

  // ---------------- behavioural model ----------------
  // Inputs are modelled as a sample history: the controller reacts to what was
  // on the pins two clocks ago; a press is a 0->1 step in that delayed view.
  state_e      m_st;
  logic        m_dir;
  int          m_t;
  logic [3:0]  hb, ha, hf;
  logic [13:0] exp_q[$];

  function automatic logic [13:0] expect_of(input state_e s);
    logic [2:0] code;
    logic [6:0] seg;
    code = s;
    seg  = (s == CLOSED) ? 7'b1000110 :
           (s == OPEN)   ? 7'b0001000 :
           (s == FAULT)  ? 7'b0000110 : 7'b0111111;
    return {code, (s == OPENING || s == CLOSING), (s == CLOSING), (s == OPENING),
            (s == CLOSING || s == FAULT), seg};
  endfunction

  task automatic model_step();
    state_e nxt;
    logic   lo, lc, pr;
    hb = {hb[2:0], botao};
    ha = {ha[2:0], aberto};
    hf = {hf[2:0], fechado};
    lo = ha[2];
    lc = hf[2];
    pr = hb[2] & ~hb[3];
    nxt = m_st;
    if (lo && lc) nxt = FAULT;
    else if (m_st == STOPPED) begin
      if (lc) nxt = CLOSED;
      else if (lo) nxt = OPEN;
      else if (pr) begin nxt = DEAD; m_dir = 1'b1; end
    end else if (m_st == CLOSED) begin
      if (pr) begin nxt = DEAD; m_dir = 1'b0; end
    end else if (m_st == OPEN) begin
      if (pr || (AUTO_CLOSE != 0 && m_t == AUTO_CLOSE - 1)) begin nxt = DEAD; m_dir = 1'b1; end
    end else if (m_st == DEAD) begin
      if (m_t == DEAD_CYCLES - 1) nxt = m_dir ? CLOSING : OPENING;
      else if (pr) m_dir = ~m_dir;
    end else if (m_st == OPENING || m_st == CLOSING) begin
      if ((m_st == OPENING) ? lo : lc) nxt = (m_st == OPENING) ? OPEN : CLOSED;
      else if (pr) begin nxt = DEAD; m_dir = (m_st == OPENING); end
      else if (m_t == TRAVEL_MAX - 1) nxt = FAULT;
    end
    m_t  = (nxt == m_st) ? m_t + 1 : 0;
    m_st = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_st = STOPPED; m_dir = 1'b1; m_t = 0;
        hb = '0; ha = '0; hf = '0;
        exp_q.delete();
        exp_q.push_back(expect_of(STOPPED));
      end else begin
        model_step();
        exp_q.push_back(expect_of(m_st));
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic prev_m = 1'b0;
  logic prev_s = 1'b0;

  initial begin
    logic [13:0] e, a;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        e = exp_q.pop_front();
        a = {dbg_state, motor, sentido, ledVerde, ledVermelho, display};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL cycle_check t=%0t got st=%0d m%b s%b g%b r%b d=%b, expected st=%0d m%b s%b g%b r%b d=%b",
                   $time, a[13:11], a[10], a[9], a[8], a[7], a[6:0],
                   e[13:11], e[10], e[9], e[8], e[7], e[6:0]);
        end
        if (prev_m && motor) begin
          n_vec++;
          if (sentido !== prev_s) begin
            n_err++;
            $display("FAIL sentido_stable t=%0t got %b, expected %b", $time, sentido, prev_s);
          end
        end
        prev_m = motor;
        prev_s = sentido;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input logic a, input logic f);
    @(negedge clock);
    #2 reset = 1'b1;
    botao = 1'b0; aberto = a; fechado = f;
    clk_wait(2);
    reset = 1'b0;
  endtask

  // Pulse the button for one clock; returns one negedge later
  task automatic press_btn();
    botao = 1'b1;
    clk_wait(1);
    botao = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got no finish, expected finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset with the gate closed
    do_reset(1'b0, 1'b1);
    chk("reset_display", display, 7'b0111111);
    clk_wait(3);
    chk("t1_display_C", display, 7'b1000110);
    chk("t1_motor", motor, 0);

    // 2: press from CLOSED -> dead time -> opening -> open limit
    fechado = 1'b0;
    press_btn();
    clk_wait(4);
    chk("t2_dead_motor", motor, 0);
    clk_wait(1);
    chk("t2_open_motor", motor, 1);
    chk("t2_open_sentido", sentido, 0);
    chk("t2_ledVerde", ledVerde, 1);
    aberto = 1'b1;
    clk_wait(3);
    chk("t2_display_A", display, 7'b0001000);
    aberto = 1'b0;

    // 3: auto-close after 30 cycles in OPEN
    clk_wait(29);
    chk("t3_still_open", display, 7'b0001000);
    clk_wait(1);
    chk("t3_dead_display", display, 7'b0111111);
    chk("t3_dead_motor", motor, 0);
    clk_wait(3);
    chk("t3_close_motor", motor, 1);
    chk("t3_close_sentido", sentido, 1);
    chk("t3_ledVermelho", ledVermelho, 1);
    fechado = 1'b1;
    clk_wait(3);
    chk("t3_display_C", display, 7'b1000110);

    // 4: reversal while opening
    fechado = 1'b0;
    press_btn();
    clk_wait(5);
    chk("t4_opening", motor, 1);
    clk_wait(5);
    press_btn();
    clk_wait(1);
    chk("t4_motor_before_dead", motor, 1);
    clk_wait(1);
    chk("t4_dead_first", motor, 0);
    clk_wait(2);
    chk("t4_dead_last", motor, 0);
    clk_wait(1);
    chk("t4_rev_motor", motor, 1);
    chk("t4_rev_sentido", sentido, 1);

    // 5: closing with no limit -> travel timeout fault
    clk_wait(19);
    chk("t5_before_timeout", motor, 1);
    clk_wait(1);
    chk("t5_fault_motor", motor, 0);
    chk("t5_fault_display", display, 7'b0000110);
    chk("t5_fault_led", ledVermelho, 1);
    press_btn();
    clk_wait(6);
    chk("t5_fault_sticky", display, 7'b0000110);

    // 6a: open limit arriving on the travel terminal cycle counts as success
    do_reset(1'b0, 1'b1);
    clk_wait(3);
    fechado = 1'b0;
    press_btn();
    clk_wait(5);
    chk("t6a_opening", ledVerde, 1);
    clk_wait(16);
    aberto = 1'b1;
    clk_wait(3);
    chk("t6a_limit_beats_timeout", display, 7'b0001000);

    // 6b: second press during dead time flips the pending direction
    botao = 1'b1; clk_wait(1);
    botao = 1'b0; clk_wait(1);
    botao = 1'b1; clk_wait(1);
    botao = 1'b0;
    clk_wait(3);
    chk("t6b_inverted_opening", ledVerde, 1);
    chk("t6b_inverted_sentido", sentido, 0);
    clk_wait(1);
    chk("t6b_back_open", display, 7'b0001000);

    // 6c: reset mid-opening drops the motor immediately
    do_reset(1'b0, 1'b1);
    clk_wait(3);
    fechado = 1'b0;
    press_btn();
    clk_wait(7);
    chk("t6c_opening", motor, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6c_async_motor", motor, 0);
    chk("t6c_async_state", dbg_state, STOPPED);
    @(negedge clock);
    reset = 1'b0;
    clk_wait(4);
    chk("t6c_stopped", dbg_state, STOPPED);
    press_btn();
    clk_wait(5);
    chk("t6c_stopped_press_closes", sentido, 1);
    chk("t6c_stopped_press_motor", motor, 1);
    aberto = 1'b1;
    fechado = 1'b1;
    clk_wait(3);
    chk("t6c_both_limits_fault", display, 7'b0000110);
    chk("t6c_both_limits_motor", motor, 0);
    clk_wait(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
